uart_tx_module: RTL and testbench

Transmit path of the UART: a byte-write FIFO, a 16x-oversampled baud tick generator and a serializer FSM that drives the serial line. It is the transmit counterpart of the receive path. Host logic pushes bytes with `wr_en`, and the block emits standard 8N1-style frames (start bit, DATA_WIDTH data bits LSB first, stop bit) on `tx_o` until the FIFO drains.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx.sv | 122 ++++++++++++
 rtl/uart_tx_module.sv | 110 +++++++++++
 tb/tb_uart_tx_module.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART transmit and receive paths.
package uart_pkg;

  // Oversample ticks per data/start bit.
  localparam int OVERSAMPLE = 16;

  // Serializer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_tx.sv
// uart_tx: frame serializer. Pulls one byte from the FIFO head and emits
// start bit, DATA_WIDTH data bits (LSB first) and stop bit on a registered line.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_TICKS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick_i,
  input  logic [DATA_WIDTH-1:0] head_i,
  input  logic                  not_empty_i,
  output logic                  rd_en_o,
  output logic                  tx_o,
  output logic                  busy_o
);

  // Tick counter must hold both the 16 ticks of a data bit and the stop length.
  localparam int TICK_MAX = (STOP_TICKS > OVERSAMPLE) ? STOP_TICKS : OVERSAMPLE;
  localparam int TCNT_W   = $clog2(TICK_MAX);
  localparam int BCNT_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [TCNT_W-1:0] BIT_LAST  = TCNT_W'(OVERSAMPLE - 1);
  localparam logic [TCNT_W-1:0] STOP_LAST = TCNT_W'(STOP_TICKS - 1);
  localparam logic [BCNT_W-1:0] DATA_LAST = BCNT_W'(DATA_WIDTH - 1);

  tx_state_t             state_q, state_d;
  logic [TCNT_W-1:0]     tcnt_q, tcnt_d;
  logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;

  // Next-state logic; the line level is derived from the next state so it
  // changes on the same edge as the state transition.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    rd_en_o = 1'b0;
    tx_d    = 1'b1;

    case (state_q)
      IDLE: begin
        if (not_empty_i) begin
          shift_d = head_i;
          rd_en_o = 1'b1;
          tcnt_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (tick_i) begin
          if (tcnt_q == BIT_LAST) begin
            tcnt_d  = '0;
            bcnt_d  = '0;
            state_d = DATA;
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
      end
      DATA: begin
        if (tick_i) begin
          if (tcnt_q == BIT_LAST) begin
            tcnt_d  = '0;
            shift_d = shift_q >> 1;
            if (bcnt_q == DATA_LAST) begin
              state_d = STOP;
            end else begin
              bcnt_d = bcnt_q + BCNT_W'(1);
            end
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
      end
      STOP: begin
        if (tick_i) begin
          if (tcnt_q == STOP_LAST) begin
            tcnt_d  = '0;
            state_d = IDLE;
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // Control state, counters and the line register; reset abandons any frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      tx_q    <= tx_d;
    end
  end

  // Shift register holds only data and is always reloaded before use.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign tx_o   = tx_q;
  assign busy_o = (state_q != IDLE);

endmodule

// File: rtl/uart_tx_module.sv
// uart_tx_module: UART transmit path = byte FIFO + oversample baud tick
// generator + frame serializer.
module uart_tx_module
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int FIFO_DEPTH      = 16,
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int BAUDCOUNT       = 78,
  parameter int STOP_TICKS      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  tx_o,
  output logic                  tx_busy,
  output logic                  fifo_full,
  output logic                  fifo_empty
);

  localparam int CNT_W  = FIFO_ADDR_WIDTH + 1;
  localparam int BAUD_W = (BAUDCOUNT > 1) ? $clog2(BAUDCOUNT) : 1;

  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(BAUDCOUNT - 1);

  logic [DATA_WIDTH-1:0]      mem_q [FIFO_DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [FIFO_ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [BAUD_W-1:0]          baud_q, baud_d;

  logic                  wr_acc;
  logic                  rd_en;
  logic                  rd_acc;
  logic                  tick;
  logic [DATA_WIDTH-1:0] head;

  // A write while full is dropped even if a pop happens in the same cycle.
  assign fifo_full  = (count_q == FULL_COUNT);
  assign fifo_empty = (count_q == '0);
  assign wr_acc     = wr_en && !fifo_full;
  assign rd_acc     = rd_en && !fifo_empty;
  assign head       = mem_q[rptr_q];

  // Baud counter is parked at 0 while idle so the start bit begins a full tick period.
  assign tick = (baud_q == BAUD_LAST);

  // FIFO pointer/count and baud counter next-state.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    baud_d  = '0;

    if (wr_acc) begin
      wptr_d = wptr_q + FIFO_ADDR_WIDTH'(1);
    end
    if (rd_acc) begin
      rptr_d = rptr_q + FIFO_ADDR_WIDTH'(1);
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (tx_busy && !tick) begin
      baud_d = baud_q + BAUD_W'(1);
    end
  end

  // Control registers: reset flushes the FIFO and parks the baud counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      baud_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      baud_q  <= baud_d;
    end
  end

  // FIFO storage; contents are meaningless once the pointers are reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wptr_q] <= din;
    end
  end

  uart_tx #(
    .DATA_WIDTH (DATA_WIDTH),
    .STOP_TICKS (STOP_TICKS)
  ) u_tx (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_i      (tick),
    .head_i      (head),
    .not_empty_i (!fifo_empty),
    .rd_en_o     (rd_en),
    .tx_o        (tx_o),
    .busy_o      (tx_busy)
  );

endmodule

// File: tb/tb_uart_tx_module.sv
// tb_uart_tx_module: randomized + directed bench with a queue scoreboard.
// The reference model treats the block as "accepted bytes leave in order as
// fixed-length frames"; the monitor rebuilds each expected line waveform from
// the byte alone.
module tb_uart_tx_module;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int BC    = 4;
  localparam int ST    = 16;
  localparam int BITC  = 16 * BC;               // clocks per start/data bit
  localparam int FRAME = 9 * BITC + ST * BC;    // clocks per whole frame

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] din = '0;
  logic          tx_o;
  logic          tx_busy;
  logic          fifo_full;
  logic          fifo_empty;

  uart_tx_module #(
    .DATA_WIDTH      (DW),
    .FIFO_DEPTH      (DEPTH),
    .FIFO_ADDR_WIDTH (AW),
    .BAUDCOUNT       (BC),
    .STOP_TICKS      (ST)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .din        (din),
    .tx_o       (tx_o),
    .tx_busy    (tx_busy),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Bytes accepted by the model and not yet seen starting on the line.
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Ideal line level k clocks after the start-bit edge of a frame carrying b.
  function automatic logic exp_level(input logic [DW-1:0] b, input int k);
    if (k < BITC) return 1'b0;
    else if (k < 9 * BITC) return b[(k - BITC) / BITC];
    else return 1'b1;
  endfunction

  // Inputs change 2 time units after a rising edge; the monitor samples at 1.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Offer a byte; the model accepts it only if fewer than DEPTH bytes are pending.
  task automatic push(input logic [DW-1:0] b);
    check("fifo_full_flag", fifo_full, (exp_q.size() == DEPTH));
    check("fifo_empty_flag", fifo_empty, (exp_q.size() == 0));
    wr_en = 1'b1;
    din   = b;
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    step();
    wr_en = 1'b0;
  endtask

  logic          mon_in_frame = 1'b0;
  logic          mon_expect_start = 1'b0;
  logic          mon_known = 1'b0;
  int            mon_k = 0;
  int            mon_bad = 0;
  int            mon_first_bad = 0;
  logic [DW-1:0] mon_cur = '0;
  logic [DW-1:0] mon_act = '0;

  // Monitor: detect each start bit, pop the expected byte, check every clock
  // of the frame, the decoded byte, and the single idle clock that follows.
  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      mon_in_frame     = 1'b0;
      mon_expect_start = 1'b0;
    end else begin
      if (!mon_in_frame) begin
        if (mon_expect_start) begin
          mon_expect_start = 1'b0;
          check("next_frame_after_one_idle_clk", tx_o, 1'b0);
        end
        if (tx_o === 1'b0) begin
          mon_in_frame  = 1'b1;
          mon_k         = 0;
          mon_bad       = 0;
          mon_first_bad = 0;
          mon_act       = '0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            mon_known = 1'b0;
            $display("FAIL frame_start: got a start bit, required none (nothing queued, t=%0t)", $time);
          end else begin
            mon_known = 1'b1;
            mon_cur   = exp_q.pop_front();
          end
          check("empty_after_pop", fifo_empty, (exp_q.size() == 0));
          check("full_after_pop", fifo_full, (exp_q.size() == DEPTH));
        end
      end
      if (mon_in_frame) begin
        if (mon_k < FRAME) begin
          if (mon_known && (tx_o !== exp_level(mon_cur, mon_k) || tx_busy !== 1'b1)) begin
            if (mon_bad == 0) mon_first_bad = mon_k;
            mon_bad++;
          end
          if (mon_k >= BITC && mon_k < 9 * BITC && (mon_k % BITC) == BITC / 2)
            mon_act[(mon_k / BITC) - 1] = tx_o;
          mon_k++;
        end else begin
          if (mon_known) begin
            check("frame_byte", mon_act, mon_cur);
            checks++;
            if (mon_bad != 0) begin
              errors++;
              $display("FAIL frame_wave: got %0d wrong clocks (first at %0d) for byte %0h, required 0",
                       mon_bad, mon_first_bad, mon_cur);
            end
          end
          check("gap_tx_high", tx_o, 1'b1);
          check("gap_not_busy", tx_busy, 1'b0);
          mon_expect_start = (exp_q.size() != 0);
          mon_in_frame     = 1'b0;
        end
      end
    end
  end

  // Wait (bounded) until every accepted byte has been fully transmitted.
  task automatic drain(input string name);
    int lim;
    lim = 0;
    while ((exp_q.size() != 0 || mon_in_frame || tx_busy !== 1'b0) && lim < 30000) begin
      step();
      lim++;
    end
    checks++;
    if (lim >= 30000) begin
      errors++;
      $display("FAIL %s: got %0d bytes still pending after %0d clocks, required 0", name, exp_q.size(), lim);
    end
    repeat (3) step();
  endtask

  initial begin
    int            n;
    int            cnt;
    int            lows;
    logic [9:0]    a5_seq;
    logic [DW-1:0] lb [4];

    a5_seq = 10'b1101001010;  // index 0 first: 0,1,0,1,0,0,1,0,1,1
    lb[0] = 8'h00; lb[1] = 8'h5A; lb[2] = 8'hFF; lb[3] = 8'h81;

    // Reset state
    rst_n = 1'b0;
    repeat (3) step();
    check("reset_tx", tx_o, 1'b1);
    check("reset_busy", tx_busy, 1'b0);
    check("reset_empty", fifo_empty, 1'b1);
    check("reset_full", fifo_full, 1'b0);
    rst_n = 1'b1;
    lows = 0;
    repeat (1000) begin
      step();
      if (tx_o !== 1'b1 || tx_busy !== 1'b0) lows++;
    end
    check("idle_line_disturbed_clocks", lows, 0);

    // Single byte: latency, bit table and busy length
    push(8'hA5);
    check("a5_tx_before_pop", tx_o, 1'b1);
    check("a5_busy_before_pop", tx_busy, 1'b0);
    check("a5_entry_visible", fifo_empty, 1'b0);
    step();
    check("a5_start_fall", tx_o, 1'b0);
    check("a5_busy_rise", tx_busy, 1'b1);
    check("a5_empty_after_pop", fifo_empty, 1'b1);
    cnt = 0;
    while (tx_busy === 1'b1 && cnt < 2000) begin
      if ((cnt % BITC) == BITC / 2 && cnt < 10 * BITC) check("a5_bit", tx_o, a5_seq[cnt / BITC]);
      cnt++;
      step();
    end
    check("a5_busy_clocks", cnt, FRAME);
    drain("drain_single");

    // Back-to-back frames
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    drain("drain_b2b");

    // Overflow while busy
    push(8'h77);
    step();
    for (int i = 1; i <= 17; i++) push(8'(i));
    step();
    check("overflow_full", fifo_full, 1'b1);
    drain("drain_overflow");

    // Reset during data bit 3 of 0x55 with two entries queued
    push(8'h55);
    push(8'h3A);
    push(8'hC3);
    repeat (4 * BITC + 14) step();
    rst_n = 1'b0;
    exp_q.delete();
    step();
    check("midreset_tx", tx_o, 1'b1);
    check("midreset_empty", fifo_empty, 1'b1);
    check("midreset_busy", tx_busy, 1'b0);
    check("midreset_full", fifo_full, 1'b0);
    step();
    rst_n = 1'b1;
    lows = 0;
    repeat (2000) begin
      step();
      if (tx_o !== 1'b1) lows++;
    end
    check("after_reset_line_low_clocks", lows, 0);

    // Loopback-style byte sequence
    for (int i = 0; i < 4; i++) begin
      push(lb[i]);
      repeat ($urandom_range(0, 3)) step();
    end
    drain("drain_loopback");

    // Randomized bursts and gaps, one burst large enough to overflow
    for (int r = 0; r < 14; r++) begin
      n = (r == 7) ? 20 : int'($urandom_range(1, 3));
      for (int j = 0; j < n; j++) push(8'($urandom));
      repeat ($urandom_range(0, 900)) step();
    end
    drain("drain_random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
